// File: rtl/lcd_bitmap_window.sv
// Draws a 1-bpp ROM bitmap into an LCD window: window-address words, then two RGB565 bytes per pixel.
// Bit order within a row is LSB first; define LCD_BITMAP_MSB_FIRST_EN to select MSB first.
module lcd_bitmap_window #(
    parameter int ROM_W   = 240,
    parameter int ROM_AW  = 9,
    parameter int ROM_LAT = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic [8:0]        x_start,
    input  logic [8:0]        x_end,
    input  logic [8:0]        y_start,
    input  logic [8:0]        y_end,
    input  logic [15:0]       fg_color,
    input  logic [15:0]       bg_color,
    input  logic              wr_done,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [ROM_W-1:0]  rom_q,
    output logic [8:0]        lcd_data,
    output logic              lcd_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, CHECK, WIN, FETCH, PIX, DONE} state_t;

    localparam logic [2:0] LAT = 3'(ROM_LAT);

    state_t             r_state;
    logic [8:0]         r_xs, r_xe, r_ys, r_ye;
    logic [15:0]        r_fg, r_bg;
    logic [8:0]         r_wm1, r_hm1;
    logic [8:0]         r_row, r_px;
    logic [3:0]         r_widx;
    logic [2:0]         r_lat;
    logic               r_half;
    logic               r_wait;
    logic [ROM_W-1:0]   r_shift;
    logic [ROM_AW-1:0]  r_rom_addr;
    logic [8:0]         r_lcd_data;
    logic               r_lcd_en, r_busy, r_done, r_err;

    logic [9:0]         w_width;
    logic               w_reject;
    logic [15:0]        w_xs, w_xe, w_ys, w_ye;
    logic [8:0]         w_win_word;
    logic               w_bit;
    logic [15:0]        w_color;
    logic [8:0]         w_pix_word;

    assign w_width  = {1'b0, r_xe} - {1'b0, r_xs} + 10'd1;
    assign w_reject = (r_xe < r_xs) || (r_ye < r_ys) || (32'(w_width) > ROM_W);

    assign w_xs = {7'd0, r_xs};
    assign w_xe = {7'd0, r_xe};
    assign w_ys = {7'd0, r_ys};
    assign w_ye = {7'd0, r_ye};

    always_comb begin
        w_win_word = 9'h02A;
        case (r_widx)
            4'd0:    w_win_word = 9'h02A;
            4'd1:    w_win_word = {1'b1, w_xs[15:8]};
            4'd2:    w_win_word = {1'b1, w_xs[7:0]};
            4'd3:    w_win_word = {1'b1, w_xe[15:8]};
            4'd4:    w_win_word = {1'b1, w_xe[7:0]};
            4'd5:    w_win_word = 9'h02B;
            4'd6:    w_win_word = {1'b1, w_ys[15:8]};
            4'd7:    w_win_word = {1'b1, w_ys[7:0]};
            4'd8:    w_win_word = {1'b1, w_ye[15:8]};
            4'd9:    w_win_word = {1'b1, w_ye[7:0]};
            default: w_win_word = 9'h02C;
        endcase
    end

    // The current pixel's bit always sits at one end of the shift register.
`ifdef LCD_BITMAP_MSB_FIRST_EN
    assign w_bit = r_shift[ROM_W-1];
`else
    assign w_bit = r_shift[0];
`endif

    assign w_color    = w_bit ? r_fg : r_bg;
    assign w_pix_word = r_half ? {1'b1, w_color[7:0]} : {1'b1, w_color[15:8]};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= IDLE;
            r_xs       <= '0;
            r_xe       <= '0;
            r_ys       <= '0;
            r_ye       <= '0;
            r_fg       <= '0;
            r_bg       <= '0;
            r_wm1      <= '0;
            r_hm1      <= '0;
            r_row      <= '0;
            r_px       <= '0;
            r_widx     <= '0;
            r_lat      <= '0;
            r_half     <= 1'b0;
            r_wait     <= 1'b0;
            r_shift    <= '0;
            r_rom_addr <= '0;
            r_lcd_data <= '0;
            r_lcd_en   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_lcd_en <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (start && !r_done) begin
                        r_xs    <= x_start;
                        r_xe    <= x_end;
                        r_ys    <= y_start;
                        r_ye    <= y_end;
                        r_fg    <= fg_color;
                        r_bg    <= bg_color;
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    r_wm1  <= r_xe - r_xs;
                    r_hm1  <= r_ye - r_ys;
                    r_widx <= '0;
                    r_row  <= '0;
                    r_px   <= '0;
                    r_half <= 1'b0;
                    r_wait <= 1'b0;
                    if (w_reject) begin
                        r_err   <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_state <= WIN;
                    end
                end
                WIN: begin
                    if (!r_wait) begin
                        r_lcd_en   <= 1'b1;
                        r_lcd_data <= w_win_word;
                        r_wait     <= 1'b1;
                    end else if (wr_done) begin
                        r_wait <= 1'b0;
                        if (r_widx == 4'd10) begin
                            r_rom_addr <= '0;
                            r_lat      <= '0;
                            r_state    <= FETCH;
                        end else begin
                            r_widx <= r_widx + 4'd1;
                        end
                    end
                end
                FETCH: begin
                    if (r_lat == LAT) begin
                        r_shift <= rom_q;
                        r_state <= PIX;
                    end else begin
                        r_lat <= r_lat + 3'd1;
                    end
                end
                PIX: begin
                    if (!r_wait) begin
                        r_lcd_en   <= 1'b1;
                        r_lcd_data <= w_pix_word;
                        r_wait     <= 1'b1;
                    end else if (wr_done) begin
                        r_wait <= 1'b0;
                        r_half <= ~r_half;
                        if (r_half) begin
`ifdef LCD_BITMAP_MSB_FIRST_EN
                            r_shift <= r_shift << 1;
`else
                            r_shift <= r_shift >> 1;
`endif
                            if (r_px == r_wm1) begin
                                r_px <= '0;
                                if (r_row == r_hm1) begin
                                    r_state <= DONE;
                                end else begin
                                    r_row      <= r_row + 9'd1;
                                    r_rom_addr <= ROM_AW'(r_row + 9'd1);
                                    r_lat      <= '0;
                                    r_state    <= FETCH;
                                end
                            end else begin
                                r_px <= r_px + 9'd1;
                            end
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rom_addr = r_rom_addr;
    assign lcd_data = r_lcd_data;
    assign lcd_en   = r_lcd_en;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule
